// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the APB master arbiter.
// The rotating-priority mask function is used by the round-robin selector.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_ADDR_W         = 8;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_TIMEOUT_CYCLES = 16;

    // Bit idx of the rotating mask: requesters at or above the pointer take priority.
    function automatic logic rr_mask_bit(input int idx, input int ptr);
        return (idx >= ptr);
    endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin selector: first request at or above ptr_i, wrapping to index 0.
// Zero latency; no backpressure, grant is valid whenever any request is set.
module apb_rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               vld_o
);

    logic [NUM_REQ-1:0] masked;
    logic [NUM_REQ-1:0] pick;
    logic               found;

    always_comb begin
        masked = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            masked[i] = req_i[i] & rr_mask_bit(i, int'(ptr_i));
        end
        // Nothing at or above the pointer: wrap and search from index 0.
        pick  = (|masked) ? masked : req_i;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i] && !found) begin
                found    = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = IDX_W'(i);
            end
        end
        vld_o = |req_i;
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin share of one APB master: accept -> BUSY (transfer held) -> RESP (1-cycle rsp pulse) -> IDLE.
// Requesters stall on req_ready outside IDLE; APB_ARB_TIMEOUT_EN adds a BUSY watchdog and timeout port.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int STRB_W         = DATA_W / 8,
`ifdef APB_ARB_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
`endif
    localparam int IDX_W         = $clog2(NUM_REQ)
) (
    input  logic                      PCLK,
    input  logic                      PRESET_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ*STRB_W-1:0] req_strb,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_error,
    output logic                      transfer,
    output logic                      write_read,
    output logic [ADDR_W-1:0]         addr_in,
    output logic [DATA_W-1:0]         wdata_in,
    output logic [STRB_W-1:0]         strb_in,
    input  logic                      transfer_done,
    input  logic                      error,
    input  logic [DATA_W-1:0]         rdata_out,
    output logic [IDX_W-1:0]          grant_id,
`ifdef APB_ARB_TIMEOUT_EN
    output logic                      timeout,
`endif
    output logic                      busy
);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   strb_q, strb_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [NUM_REQ-1:0]  arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_vld;
`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                timeout_q, timeout_d;
`endif

    apb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .vld_o (arb_vld)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    state_d = BUSY;
                    grant_d = arb_idx;
`ifdef APB_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (arb_gnt[i]) begin
                            write_d = req_write[i];
                            addr_d  = req_addr[i*ADDR_W +: ADDR_W];
                            // Reads carry no data or strobes toward the master.
                            wdata_d = req_write[i] ? req_wdata[i*DATA_W +: DATA_W] : '0;
                            strb_d  = req_write[i] ? req_strb[i*STRB_W +: STRB_W] : '0;
                        end
                    end
                end
            end
            BUSY: begin
                if (transfer_done) begin
                    state_d = RESP;
                    rdata_d = write_q ? '0 : rdata_out;
                    err_d   = error;
                end
`ifdef APB_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = RESP;
                    rdata_d   = '0;
                    err_d     = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
                ptr_d   = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef APB_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    always_comb begin
        req_ready = (state_q == IDLE) ? arb_gnt : '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = (state_q == RESP) && (grant_q == IDX_W'(i));
        end
    end

    assign transfer   = (state_q == BUSY);
    assign write_read = transfer & write_q;
    assign addr_in    = transfer ? addr_q  : '0;
    assign wdata_in   = transfer ? wdata_q : '0;
    assign strb_in    = transfer ? strb_q  : '0;
    assign rsp_rdata  = rdata_q;
    assign rsp_error  = err_q;
    assign grant_id   = grant_q;
    assign busy       = (state_q != IDLE);
`ifdef APB_ARB_TIMEOUT_EN
    assign timeout    = timeout_q;
`endif

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed self-checking bench for apb_master_arbiter (4 requesters, 8-bit addr, 32-bit data).
module tb_apb_master_arbiter;

    logic         PCLK;
    logic         PRESET_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_write;
    logic [31:0]  req_addr;
    logic [127:0] req_wdata;
    logic [15:0]  req_strb;
    logic [3:0]   req_ready;
    logic [3:0]   rsp_valid;
    logic [31:0]  rsp_rdata;
    logic         rsp_error;
    logic         transfer;
    logic         write_read;
    logic [7:0]   addr_in;
    logic [31:0]  wdata_in;
    logic [3:0]   strb_in;
    logic         transfer_done;
    logic         error;
    logic [31:0]  rdata_out;
    logic [1:0]   grant_id;
    logic         busy;
`ifdef APB_ARB_TIMEOUT_EN
    logic         timeout;
`endif

    int checks = 0;
    int errors = 0;

    apb_master_arbiter dut (
        .PCLK          (PCLK),
        .PRESET_n      (PRESET_n),
        .req_valid     (req_valid),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_strb      (req_strb),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_error     (rsp_error),
        .transfer      (transfer),
        .write_read    (write_read),
        .addr_in       (addr_in),
        .wdata_in      (wdata_in),
        .strb_in       (strb_in),
        .transfer_done (transfer_done),
        .error         (error),
        .rdata_out     (rdata_out),
        .grant_id      (grant_id),
`ifdef APB_ARB_TIMEOUT_EN
        .timeout       (timeout),
`endif
        .busy          (busy)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    task automatic test_reset;
        #3;
        checks++; if (transfer !== 1'b0) begin errors++; $display("FAIL reset_transfer: got %b exp 0", transfer); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id: got %0d exp 0", grant_id); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b exp 0000", req_ready); end
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b exp 0000", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0 || rsp_error !== 1'b0) begin errors++; $display("FAIL reset_rsp: got %h/%b exp 0/0", rsp_rdata, rsp_error); end
        checks++; if (addr_in !== 8'h0 || wdata_in !== 32'h0 || strb_in !== 4'h0) begin errors++; $display("FAIL reset_cmd: got %h/%h/%h exp 0", addr_in, wdata_in, strb_in); end
        tick;
        PRESET_n = 1'b1;
        tick;
    endtask

    task automatic test_write;
        req_write[0]        = 1'b1;
        req_addr[7:0]       = 8'h10;
        req_wdata[31:0]     = 32'hDEADBEEF;
        req_strb[3:0]       = 4'hF;
        req_valid           = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wr_req_ready: got %b exp 0001", req_ready); end
        tick;
        req_valid = 4'b0000;
        checks++; if (transfer !== 1'b1) begin errors++; $display("FAIL wr_transfer_c1: got %b exp 1", transfer); end
        checks++; if (write_read !== 1'b1 || addr_in !== 8'h10) begin errors++; $display("FAIL wr_cmd: got wr=%b addr=%h exp 1/10", write_read, addr_in); end
        checks++; if (wdata_in !== 32'hDEADBEEF || strb_in !== 4'hF) begin errors++; $display("FAIL wr_data: got %h/%h exp deadbeef/f", wdata_in, strb_in); end
        checks++; if (req_ready !== 4'b0000 || busy !== 1'b1 || grant_id !== 2'd0) begin errors++; $display("FAIL wr_busy: got rdy=%b busy=%b gid=%0d exp 0000/1/0", req_ready, busy, grant_id); end
        tick;
        checks++; if (transfer !== 1'b1) begin errors++; $display("FAIL wr_transfer_c2: got %b exp 1", transfer); end
        tick;
        checks++; if (transfer !== 1'b1 || addr_in !== 8'h10) begin errors++; $display("FAIL wr_transfer_c3: got %b/%h exp 1/10", transfer, addr_in); end
        transfer_done = 1'b1;
        rdata_out     = 32'h12345678;
        tick;
        transfer_done = 1'b0;
        rdata_out     = 32'h0;
        checks++; if (transfer !== 1'b0) begin errors++; $display("FAIL wr_transfer_drop: got %b exp 0", transfer); end
        checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL wr_rsp_valid: got %b exp 0001", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0 || rsp_error !== 1'b0) begin errors++; $display("FAIL wr_rsp: got %h/%b exp 0/0", rsp_rdata, rsp_error); end
        tick;
        checks++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL wr_idle: got %b/%b exp 0000/0", rsp_valid, busy); end
    endtask

    // Pointer is 1 after the single write, so the fair order starts at 1.
    task automatic test_round_robin;
        int exp_order[5] = '{1, 2, 3, 0, 1};
        req_write = 4'b1111;
        req_addr  = {8'h23, 8'h22, 8'h21, 8'h20};
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (req_ready !== 4'(1 << exp_order[k])) begin errors++; $display("FAIL rr_ready[%0d]: got %b exp %b", k, req_ready, 4'(1 << exp_order[k])); end
            tick;
            checks++; if (grant_id !== 2'(exp_order[k]) || addr_in !== 8'(8'h20 + exp_order[k])) begin errors++; $display("FAIL rr_grant[%0d]: got %0d/%h exp %0d", k, grant_id, addr_in, exp_order[k]); end
            transfer_done = 1'b1;
            tick;
            transfer_done = 1'b0;
            checks++; if (rsp_valid !== 4'(1 << exp_order[k])) begin errors++; $display("FAIL rr_rsp[%0d]: got %b exp %b", k, rsp_valid, 4'(1 << exp_order[k])); end
            tick;
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_read;
        req_write[2]      = 1'b0;
        req_addr[23:16]   = 8'h44;
        req_wdata[95:64]  = 32'hFFFFFFFF;
        req_strb[11:8]    = 4'hF;
        req_valid         = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rd_ready: got %b exp 0100", req_ready); end
        tick;
        req_valid = 4'b0000;
        checks++; if (write_read !== 1'b0 || addr_in !== 8'h44 || grant_id !== 2'd2) begin errors++; $display("FAIL rd_cmd: got wr=%b addr=%h gid=%0d exp 0/44/2", write_read, addr_in, grant_id); end
        checks++; if (wdata_in !== 32'h0 || strb_in !== 4'h0) begin errors++; $display("FAIL rd_zero_data: got %h/%h exp 0/0", wdata_in, strb_in); end
        tick;
        checks++; if (addr_in !== 8'h44 || wdata_in !== 32'h0 || transfer !== 1'b1) begin errors++; $display("FAIL rd_stable: got %h/%h/%b exp 44/0/1", addr_in, wdata_in, transfer); end
        transfer_done = 1'b1;
        rdata_out     = 32'hA5A50001;
        tick;
        transfer_done = 1'b0;
        rdata_out     = 32'h0;
        checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL rd_rsp_valid: got %b exp 0100", rsp_valid); end
        checks++; if (rsp_rdata !== 32'hA5A50001 || rsp_error !== 1'b0) begin errors++; $display("FAIL rd_rsp: got %h/%b exp a5a50001/0", rsp_rdata, rsp_error); end
        tick;
        checks++; if (rsp_valid !== 4'b0000 || rsp_rdata !== 32'hA5A50001) begin errors++; $display("FAIL rd_hold: got %b/%h exp 0000/a5a50001", rsp_valid, rsp_rdata); end
    endtask

    // Pointer is 3 here; req1 wins by wrap, then the pointer must land on 2.
    task automatic test_error;
        req_write[1] = 1'b1;
        req_valid    = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL err_ready: got %b exp 0010", req_ready); end
        tick;
        req_valid     = 4'b0000;
        transfer_done = 1'b1;
        error         = 1'b1;
        tick;
        transfer_done = 1'b0;
        error         = 1'b0;
        checks++; if (rsp_valid !== 4'b0010 || rsp_error !== 1'b1) begin errors++; $display("FAIL err_rsp: got %b/%b exp 0010/1", rsp_valid, rsp_error); end
        tick;
        req_valid = 4'b1101;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL err_next_ptr: got %b exp 0100", req_ready); end
        req_valid     = 4'b0000;
        transfer_done = 1'b1;
        tick;
        transfer_done = 1'b0;
        checks++; if (busy !== 1'b0 || rsp_valid !== 4'b0000 || transfer !== 1'b0) begin errors++; $display("FAIL idle_ignore: got %b/%b/%b exp 0/0000/0", busy, rsp_valid, transfer); end
    endtask

    task automatic test_reset_mid_busy;
        req_write = 4'b1111;
        req_valid = 4'b1000;
        tick;
        req_valid = 4'b0000;
        checks++; if (transfer !== 1'b1 || grant_id !== 2'd3) begin errors++; $display("FAIL rst_pre: got %b/%0d exp 1/3", transfer, grant_id); end
        #2;
        PRESET_n = 1'b0;
        #1;
        checks++; if (transfer !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_async: got transfer=%b busy=%b exp 0/0", transfer, busy); end
        checks++; if (grant_id !== 2'd0 || req_ready !== 4'b0000) begin errors++; $display("FAIL rst_async_gid: got %0d/%b exp 0/0000", grant_id, req_ready); end
        tick;
        PRESET_n  = 1'b1;
        req_valid = 4'b1001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_ptr0: got %b exp 0001", req_ready); end
        tick;
        req_valid = 4'b0000;
        checks++; if (grant_id !== 2'd0 || transfer !== 1'b1) begin errors++; $display("FAIL rst_regrant: got %0d/%b exp 0/1", grant_id, transfer); end
        transfer_done = 1'b1;
        tick;
        transfer_done = 1'b0;
        checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL rst_rsp: got %b exp 0001", rsp_valid); end
        tick;
    endtask

`ifdef APB_ARB_TIMEOUT_EN
    task automatic test_timeout;
        req_write[0] = 1'b1;
        req_valid    = 4'b0001;
        rdata_out    = 32'hCAFEF00D;
        tick;
        req_valid = 4'b0000;
        repeat (15) tick;
        checks++; if (transfer !== 1'b1 || timeout !== 1'b0) begin errors++; $display("FAIL to_cycle16: got %b/%b exp 1/0", transfer, timeout); end
        tick;
        checks++; if (timeout !== 1'b1 || rsp_error !== 1'b1 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL to_fire: got %b/%b/%h exp 1/1/0", timeout, rsp_error, rsp_rdata); end
        checks++; if (transfer !== 1'b0 || rsp_valid !== 4'b0001) begin errors++; $display("FAIL to_rsp: got %b/%b exp 0/0001", transfer, rsp_valid); end
        tick;
        checks++; if (busy !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL to_idle: got %b/%b exp 0/0", busy, timeout); end
        req_write[2] = 1'b0;
        req_valid    = 4'b0100;
        tick;
        req_valid = 4'b0000;
        repeat (15) tick;
        transfer_done = 1'b1;
        rdata_out     = 32'h00000055;
        tick;
        transfer_done = 1'b0;
        checks++; if (timeout !== 1'b0 || rsp_error !== 1'b0 || rsp_rdata !== 32'h55) begin errors++; $display("FAIL to_race: got %b/%b/%h exp 0/0/55", timeout, rsp_error, rsp_rdata); end
        tick;
    endtask
`endif

    initial begin
        PRESET_n      = 1'b0;
        req_valid     = '0;
        req_write     = '0;
        req_addr      = '0;
        req_wdata     = '0;
        req_strb      = '0;
        transfer_done = 1'b0;
        error         = 1'b0;
        rdata_out     = '0;
        test_reset;
        test_write;
        test_round_robin;
        test_read;
        test_error;
        test_reset_mid_busy;
`ifdef APB_ARB_TIMEOUT_EN
        test_timeout;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

endmodule
